// File: rtl/javk_mem_arb_if.sv
// One requester port of the JAVK memory arbiter: request/write/address/data in,
// one-cycle ack and held read data out.
interface javk_mem_arb_if;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        ack;
  logic [7:0]  rdata;

  modport master (output req, we, addr, wdata, input  ack, rdata);
  modport slave  (input  req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/javk_mem_arb.sv
// Shares the external JAVK memory bus between the core port and a DMA/debug port:
// fixed CPU priority, starvation-bounded DMA, programmable wait states.
module javk_mem_arb #(
  parameter int WAIT_STATES  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  javk_mem_arb_if.slave        cpu,
  javk_mem_arb_if.slave        dma,
  output logic [15:0]          o_mem_addr,
  output logic [7:0]           o_mem_wdata,
  input  logic [7:0]           i_mem_rdata,
  output logic                 o_mem_rw,
  output logic                 o_grant_dma
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  localparam logic [3:0] LP_WAIT   = 4'(WAIT_STATES);
  localparam logic [3:0] LP_STARVE = 4'(STARVE_LIMIT);

  state_t      r_state,     w_state_nxt;
  logic [3:0]  r_wait,      w_wait_nxt;
  logic [3:0]  r_starve,    w_starve_nxt;
  logic [15:0] r_mem_addr,  w_mem_addr_nxt;
  logic [7:0]  r_mem_wdata, w_mem_wdata_nxt;
  logic        r_mem_rw,    w_mem_rw_nxt;
  logic        r_grant_dma, w_grant_dma_nxt;
  logic        r_cpu_ack,   w_cpu_ack_nxt;
  logic        r_dma_ack,   w_dma_ack_nxt;
  logic [7:0]  r_cpu_rdata, w_cpu_rdata_nxt;
  logic [7:0]  r_dma_rdata, w_dma_rdata_nxt;
  logic        w_pick_dma;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wait      <= '0;
      r_starve    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_rw    <= 1'b0;
      r_grant_dma <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_dma_ack   <= 1'b0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait      <= w_wait_nxt;
      r_starve    <= w_starve_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_rw    <= w_mem_rw_nxt;
      r_grant_dma <= w_grant_dma_nxt;
      r_cpu_ack   <= w_cpu_ack_nxt;
      r_dma_ack   <= w_dma_ack_nxt;
      r_cpu_rdata <= w_cpu_rdata_nxt;
      r_dma_rdata <= w_dma_rdata_nxt;
    end
  end

  assign w_pick_dma = dma.req && (!cpu.req || (r_starve == LP_STARVE));

  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch;
    // acks default low, which makes them single-cycle pulses.
    w_state_nxt     = r_state;
    w_wait_nxt      = r_wait;
    w_starve_nxt    = r_starve;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_rw_nxt    = r_mem_rw;
    w_grant_dma_nxt = r_grant_dma;
    w_cpu_ack_nxt   = 1'b0;
    w_dma_ack_nxt   = 1'b0;
    w_cpu_rdata_nxt = r_cpu_rdata;
    w_dma_rdata_nxt = r_dma_rdata;

    unique case (r_state)
      S_IDLE: begin
        if (w_pick_dma) begin
          w_mem_addr_nxt  = dma.addr;
          w_mem_wdata_nxt = dma.wdata;
          w_mem_rw_nxt    = dma.we;
          w_grant_dma_nxt = 1'b1;
          w_wait_nxt      = LP_WAIT;
          w_starve_nxt    = '0;
          w_state_nxt     = S_ACCESS;
        end else if (cpu.req) begin
          w_mem_addr_nxt  = cpu.addr;
          w_mem_wdata_nxt = cpu.wdata;
          w_mem_rw_nxt    = cpu.we;
          w_grant_dma_nxt = 1'b0;
          w_wait_nxt      = LP_WAIT;
          w_state_nxt     = S_ACCESS;
          if (dma.req && (r_starve != LP_STARVE))
            w_starve_nxt = r_starve + 4'd1;
        end
        // A DMA port that is not asking has nothing to be starved of.
        if (!dma.req)
          w_starve_nxt = '0;
      end

      S_ACCESS: begin
        if (r_wait == 4'd0) begin
          w_mem_rw_nxt = 1'b0;
          w_state_nxt  = S_DONE;
          if (r_grant_dma) begin
            w_dma_ack_nxt = 1'b1;
            if (!r_mem_rw) w_dma_rdata_nxt = i_mem_rdata;
          end else begin
            w_cpu_ack_nxt = 1'b1;
            if (!r_mem_rw) w_cpu_rdata_nxt = i_mem_rdata;
          end
        end else begin
          w_wait_nxt = r_wait - 4'd1;
        end
      end

      S_DONE:  w_state_nxt = S_IDLE;

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_rw    = r_mem_rw;
  assign o_grant_dma = r_grant_dma;
  assign cpu.ack     = r_cpu_ack;
  assign cpu.rdata   = r_cpu_rdata;
  assign dma.ack     = r_dma_ack;
  assign dma.rdata   = r_dma_rdata;

endmodule

// File: tb/tb_javk_mem_arb.sv
// Directed bench for javk_mem_arb: a table of single transfers with cycle-exact
// bus/ack checks, plus starvation, reset-abort and zero-wait back-to-back sequences.
module tb_javk_mem_arb;

  localparam int WS = 1;

  typedef struct {
    logic        is_dma;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata_in;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance: WAIT_STATES=1, STARVE_LIMIT=4.
  javk_mem_arb_if cpu_if();
  javk_mem_arb_if dma_if();
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_rw;
  logic        grant_dma;

  javk_mem_arb #(.WAIT_STATES(WS), .STARVE_LIMIT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu         (cpu_if.slave),
    .dma         (dma_if.slave),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata),
    .o_mem_rw    (mem_rw),
    .o_grant_dma (grant_dma)
  );

  // Zero-wait instance with a tiny memory model: data = low address byte ^ 0x5A.
  javk_mem_arb_if cpu0_if();
  javk_mem_arb_if dma0_if();
  logic [15:0] mem_addr0;
  logic [7:0]  mem_wdata0;
  logic [7:0]  mem_rdata0;
  logic        mem_rw0;
  logic        grant_dma0;

  assign mem_rdata0 = mem_addr0[7:0] ^ 8'h5A;

  javk_mem_arb #(.WAIT_STATES(0), .STARVE_LIMIT(4)) dut0 (
    .clk         (clk),
    .rst         (rst),
    .cpu         (cpu0_if.slave),
    .dma         (dma0_if.slave),
    .o_mem_addr  (mem_addr0),
    .o_mem_wdata (mem_wdata0),
    .i_mem_rdata (mem_rdata0),
    .o_mem_rw    (mem_rw0),
    .o_grant_dma (grant_dma0)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_cpu_rdata = 8'h00;
  logic [7:0] exp_dma_rdata = 8'h00;
  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cpu_if.req = 1'b0; cpu_if.we = 1'b0; cpu_if.addr = '0; cpu_if.wdata = '0;
    dma_if.req = 1'b0; dma_if.we = 1'b0; dma_if.addr = '0; dma_if.wdata = '0;
    cpu0_if.req = 1'b0; cpu0_if.we = 1'b0; cpu0_if.addr = '0; cpu0_if.wdata = '0;
    dma0_if.req = 1'b0; dma0_if.we = 1'b0; dma0_if.addr = '0; dma0_if.wdata = '0;
    mem_rdata = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cpu_ack"},   cpu_if.ack,   0);
    check({tag, "_dma_ack"},   dma_if.ack,   0);
    check({tag, "_cpu_rdata"}, cpu_if.rdata, 0);
    check({tag, "_dma_rdata"}, dma_if.rdata, 0);
    check({tag, "_mem_addr"},  mem_addr,     0);
    check({tag, "_mem_wdata"}, mem_wdata,    0);
    check({tag, "_mem_rw"},    mem_rw,       0);
    check({tag, "_grant_dma"}, grant_dma,    0);
  endtask

  // One transfer starting in an IDLE cycle (cycle 0 = now).
  task automatic xfer(input int idx, input vec_t v);
    string t;
    t = $sformatf("v%0d", idx);
    if (v.is_dma) begin
      dma_if.req = 1'b1; dma_if.we = v.we; dma_if.addr = v.addr; dma_if.wdata = v.wdata;
    end else begin
      cpu_if.req = 1'b1; cpu_if.we = v.we; cpu_if.addr = v.addr; cpu_if.wdata = v.wdata;
    end
    mem_rdata = ~v.rdata_in;
    for (int c = 1; c <= WS + 2; c++) begin
      tick();
      if (c == WS + 1) mem_rdata = v.rdata_in;
      if (c <= WS + 1) begin
        check({t, "_addr"},  mem_addr,  v.addr);
        check({t, "_wdata"}, mem_wdata, v.wdata);
        check({t, "_rw"},    mem_rw,    v.we);
        check({t, "_grant"}, grant_dma, v.is_dma);
        check({t, "_noack"}, {cpu_if.ack, dma_if.ack}, 0);
      end else begin
        if (!v.we) begin
          if (v.is_dma) exp_dma_rdata = v.rdata_in;
          else          exp_cpu_rdata = v.rdata_in;
        end
        check({t, "_cpu_ack"},   cpu_if.ack,   !v.is_dma);
        check({t, "_dma_ack"},   dma_if.ack,   v.is_dma);
        check({t, "_done_rw"},   mem_rw,       0);
        check({t, "_done_addr"}, mem_addr,     v.addr);
        check({t, "_cpu_rdata"}, cpu_if.rdata, exp_cpu_rdata);
        check({t, "_dma_rdata"}, dma_if.rdata, exp_dma_rdata);
      end
    end
    cpu_if.req = 1'b0;
    dma_if.req = 1'b0;
    mem_rdata  = 8'hEE;
    tick();
    check({t, "_idle_ack"},   {cpu_if.ack, dma_if.ack}, 0);
    check({t, "_idle_rw"},    mem_rw,       0);
    check({t, "_hold_rdata"}, {cpu_if.rdata, dma_if.rdata}, {exp_cpu_rdata, exp_dma_rdata});
  endtask

  initial begin
    int n;
    logic [15:0] a6 [3];

    vecs[0] = '{1'b0, 1'b0, 16'h1234, 8'h00, 8'hA5};  // cpu read
    vecs[1] = '{1'b1, 1'b1, 16'h8000, 8'h3C, 8'h11};  // dma write
    vecs[2] = '{1'b0, 1'b1, 16'h00FF, 8'h5A, 8'h22};  // cpu write
    vecs[3] = '{1'b1, 1'b0, 16'hFFFF, 8'h00, 8'hC3};  // dma read at top of map
    vecs[4] = '{1'b0, 1'b0, 16'h0000, 8'h77, 8'h7E};  // cpu read at zero

    // Reset held two cycles with random inputs.
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cpu_if.req = 1'($urandom); cpu_if.we = 1'($urandom);
      cpu_if.addr = 16'($urandom); cpu_if.wdata = 8'($urandom);
      dma_if.req = 1'($urandom); dma_if.we = 1'($urandom);
      dma_if.addr = 16'($urandom); dma_if.wdata = 8'($urandom);
      mem_rdata = 8'($urandom);
      tick();
      check_reset_outputs($sformatf("rst%0d", i));
    end
    clear_inputs();
    rst = 1'b0;
    tick();
    check_reset_outputs("post_rst");

    for (int i = 0; i < 5; i++) xfer(i, vecs[i]);

    // Both ports requesting continuously: DMA every fifth grant.
    cpu_if.req = 1'b1; cpu_if.we = 1'b1; cpu_if.addr = 16'h1000; cpu_if.wdata = 8'h01;
    dma_if.req = 1'b1; dma_if.we = 1'b1; dma_if.addr = 16'h2000; dma_if.wdata = 8'h02;
    n = 0;
    for (int cyc = 0; cyc < 200 && n < 10; cyc++) begin
      tick();
      check("starve_overlap", cpu_if.ack & dma_if.ack, 0);
      if (cpu_if.ack || dma_if.ack) begin
        check($sformatf("starve_order%0d", n), dma_if.ack, (n % 5) == 4);
        check($sformatf("starve_grant%0d", n), grant_dma, (n % 5) == 4);
        n++;
        if (n == 10) begin
          cpu_if.req = 1'b0;
          dma_if.req = 1'b0;
        end
      end
    end
    check("starve_count", n, 10);
    tick();
    check("starve_idle_ack", {cpu_if.ack, dma_if.ack}, 0);

    // Reset during ACCESS of a CPU write.
    cpu_if.req = 1'b1; cpu_if.we = 1'b1; cpu_if.addr = 16'h4444; cpu_if.wdata = 8'h99;
    tick();
    check("abort_rw_before", mem_rw, 1);
    rst = 1'b1;
    cpu_if.req = 1'b0;
    tick();
    rst = 1'b0;
    exp_cpu_rdata = 8'h00;
    exp_dma_rdata = 8'h00;
    check_reset_outputs("abort");
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_no_ack", cpu_if.ack, 0);
      check("abort_rw_low", mem_rw, 0);
    end
    xfer(9, '{1'b0, 1'b0, 16'h5678, 8'h00, 8'h96});

    // Zero wait states: back-to-back CPU reads, one ack every 3 cycles.
    a6[0] = 16'h0100; a6[1] = 16'h0101; a6[2] = 16'h0102;
    cpu0_if.req = 1'b1; cpu0_if.we = 1'b0; cpu0_if.addr = a6[0]; cpu0_if.wdata = 8'h00;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k % 3 == 1) begin
        check($sformatf("b2b_addr%0d", k), mem_addr0, a6[k / 3]);
        check($sformatf("b2b_rw%0d", k), mem_rw0, 0);
      end
      check($sformatf("b2b_ack%0d", k), cpu0_if.ack, (k % 3) == 2);
      if (k % 3 == 2) begin
        check($sformatf("b2b_rdata%0d", k), cpu0_if.rdata, {8'h00, a6[k / 3][7:0] ^ 8'h5A});
        if (k / 3 < 2) cpu0_if.addr = a6[k / 3 + 1];
        else           cpu0_if.req  = 1'b0;
      end
    end
    tick();
    check("b2b_final_ack", cpu0_if.ack, 0);
    check("b2b_dma_ack", dma0_if.ack, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
